i2c_bus_arbiter: RTL and testbench

Shares the single I2C bus between two local requesters (master engines) and arbitrates against external masters on the same bus. It watches synchronized/debounced SCL and SDA, detects START/STOP conditions, tracks bus-busy and bus-free intervals, and issues a one-hot grant. It sits between the SCL/SDA synchronization-and-debounce stage and the master state machines.

---
 rtl/i2c_arb_pkg.sv | 30 +++
 rtl/i2c_bus_condition_detector.sv | 44 ++++
 rtl/i2c_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg
// Shared types for the two-requester I2C bus arbiter: FSM state encoding,
// requester count, the requester-index type, and the round-robin winner
// selection.
package i2c_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    typedef enum logic [1:0] {
        WAIT_FREE = 2'd0,
        IDLE      = 2'd1,
        GRANTED   = 2'd2,
        BUSY_EXT  = 2'd3
    } arb_state_t;

    // With both requesting, the one that did not own the bus last time wins.
    function automatic req_idx_t pick_winner(input logic [NUM_REQ-1:0] req,
                                             input req_idx_t          last_owner);
        if (req == 2'b11) begin
            return ~last_owner;
        end else if (req[1]) begin
            return req_idx_t'(1);
        end else begin
            return req_idx_t'(0);
        end
    endfunction

endpackage

// File: rtl/i2c_bus_condition_detector.sv
// i2c_bus_condition_detector
// Keeps the previous-cycle SCL/SDA samples and detects START/STOP.
//   fast_clock  in   system clock
//   reset       in   asynchronous active-high reset
//   scl_in      in   debounced SCL level
//   sda_in      in   debounced SDA level
//   start_cond  out  combinational START seen on this edge
//   stop_cond   out  combinational STOP seen on this edge
//   start_det   out  registered one-cycle START pulse
//   stop_det    out  registered one-cycle STOP pulse
module i2c_bus_condition_detector (
    input  logic fast_clock,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic start_cond,
    output logic stop_cond,
    output logic start_det,
    output logic stop_det
);

    logic scl_q;
    logic sda_q;

    // SDA edge while SCL stays high across both samples.
    assign start_cond = scl_q & scl_in & sda_q & ~sda_in;
    assign stop_cond  = scl_q & scl_in & ~sda_q & sda_in;

    // Samples reset high so a bus idling high out of reset reports nothing.
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_q     <= scl_in;
            sda_q     <= sda_in;
            start_det <= start_cond;
            stop_det  <= stop_cond;
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Shares one I2C bus between two local master engines and yields to external
// masters. Tracks the bus-free window, hands out a one-hot grant round-robin.
//   fast_clock  in   system clock
//   reset       in   asynchronous active-high reset
//   scl_in      in   debounced SCL level
//   sda_in      in   debounced SDA level
//   req[1:0]    in   per-requester bus request (level)
//   done[1:0]   in   per-requester release pulse from the current owner
//   grant[1:0]  out  one-hot grant or 0, registered
//   bus_busy    out  low only while the bus is free and ungranted, registered
//   start_det   out  one-cycle pulse per START / repeated START
//   stop_det    out  one-cycle pulse per STOP
//   arb_lost    out  one-cycle pulse when an external START beats a local request
//
// state     | meaning
// WAIT_FREE | counting consecutive SCL&SDA-high cycles before the bus is free
// IDLE      | bus free, no owner
// GRANTED   | a local requester owns the bus until it pulses done
// BUSY_EXT  | an external master holds the bus until its STOP
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int BUS_FREE_CYCLES = 16
) (
    input  logic               fast_clock,
    input  logic               reset,
    input  logic               scl_in,
    input  logic               sda_in,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               bus_busy,
    output logic               start_det,
    output logic               stop_det,
    output logic               arb_lost
);

    localparam int               CNT_W    = $clog2(BUS_FREE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_FREE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arb_state_t         state;
    logic [CNT_W-1:0]   free_cnt;
    req_idx_t           last_owner;
    req_idx_t           winner;
    logic [NUM_REQ-1:0] grant_next;
    logic               start_cond;
    logic               stop_cond;

    i2c_bus_condition_detector u_cond (
        .fast_clock (fast_clock),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .start_cond (start_cond),
        .stop_cond  (stop_cond),
        .start_det  (start_det),
        .stop_det   (stop_det)
    );

    always_comb begin
        winner             = pick_winner(req, last_owner);
        grant_next         = '0;
        grant_next[winner] = 1'b1;
    end

    // last_owner doubles as the current owner's index while GRANTED.
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            state      <= WAIT_FREE;
            free_cnt   <= '0;
            last_owner <= req_idx_t'(1);
            grant      <= '0;
            bus_busy   <= 1'b1;
            arb_lost   <= 1'b0;
        end else begin
            arb_lost <= 1'b0;
            unique case (state)
                WAIT_FREE: begin
                    grant    <= '0;
                    bus_busy <= 1'b1;
                    if (start_cond) begin
                        state    <= BUSY_EXT;
                        free_cnt <= '0;
                    end else if (scl_in && sda_in) begin
                        if (free_cnt == CNT_LAST) begin
                            state    <= IDLE;
                            bus_busy <= 1'b0;
                            free_cnt <= '0;
                        end else if (free_cnt != CNT_MAX) begin
                            free_cnt <= free_cnt + CNT_W'(1);
                        end
                    end else begin
                        free_cnt <= '0;
                    end
                end
                IDLE: begin
                    // An external START on the same edge as a request wins.
                    if (start_cond) begin
                        state    <= BUSY_EXT;
                        bus_busy <= 1'b1;
                        arb_lost <= |req;
                    end else if (|req) begin
                        state      <= GRANTED;
                        grant      <= grant_next;
                        last_owner <= winner;
                        bus_busy   <= 1'b1;
                    end
                end
                GRANTED: begin
                    // Bus conditions here are the owner's own traffic.
                    if (done[last_owner]) begin
                        state    <= WAIT_FREE;
                        grant    <= '0;
                        free_cnt <= '0;
                    end
                end
                BUSY_EXT: begin
                    if (stop_cond) begin
                        state    <= WAIT_FREE;
                        free_cnt <= '0;
                    end
                end
                default: begin
                    state    <= WAIT_FREE;
                    grant    <= '0;
                    bus_busy <= 1'b1;
                    free_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    logic       fast_clock;
    logic       reset;
    logic       scl_in;
    logic       sda_in;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] grant;
    logic       bus_busy;
    logic       start_det;
    logic       stop_det;
    logic       arb_lost;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       scl;
        logic       sda;
        logic [1:0] req;
        logic [1:0] done;
        logic [1:0] exp_grant;
        logic       exp_busy;
        logic       exp_sd;
        logic       exp_pd;
        logic       exp_al;
    } vec_t;

    vec_t vecs[11];

    i2c_bus_arbiter #(.BUS_FREE_CYCLES(16)) dut (
        .fast_clock (fast_clock),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .bus_busy   (bus_busy),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .arb_lost   (arb_lost)
    );

    initial begin
        fast_clock = 1'b0;
        forever #5 fast_clock = ~fast_clock;
    end

    task automatic tick();
        @(posedge fast_clock);
        @(negedge fast_clock);
    endtask

    task automatic check(input string name, input logic [1:0] eg, input logic eb,
                         input logic esd, input logic epd, input logic eal);
        logic [5:0] act;
        logic [5:0] exp;
        act = {grant, bus_busy, start_det, stop_det, arb_lost};
        exp = {eg, eb, esd, epd, eal};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got grant/busy/sd/pd/al=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                     name, act[5:4], act[3], act[2], act[1], act[0],
                     exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // 15 busy cycles then one free cycle on a quiet bus.
    task automatic wait_free(input string tag);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check({tag, "_busy"}, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check({tag, "_free"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic grant_tick(input string tag, input logic [1:0] eg);
        tick();
        check(tag, eg, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_release(input string tag, input logic [1:0] d);
        done = d;
        tick();
        check(tag, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        done = 2'b00;
    endtask

    initial begin
        // Owner traffic while GRANTED to requester 0, then release.
        vecs[0]  = '{1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};

        reset  = 1'b1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        req    = 2'b01;
        done   = 2'b00;
        @(negedge fast_clock);
        check("reset_state", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("reset_fsm", int'(dut.state), int'(WAIT_FREE));
        reset = 1'b0;

        // Quiet bus after reset: free in cycle 16, grant in cycle 17.
        wait_free("boot");
        grant_tick("boot_grant", 2'b01);

        for (int i = 0; i < 11; i++) begin
            scl_in = vecs[i].scl;
            sda_in = vecs[i].sda;
            req    = vecs[i].req;
            done   = vecs[i].done;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_busy,
                  vecs[i].exp_sd, vecs[i].exp_pd, vecs[i].exp_al);
        end
        done = 2'b00;

        // Round robin: last owner was 0, so a tie goes to 1, then back to 0.
        wait_free("rr1");
        grant_tick("rr1_grant", 2'b10);
        do_release("rr1_rel", 2'b10);
        wait_free("rr2");
        grant_tick("rr2_grant", 2'b01);
        do_release("rr2_rel", 2'b01);
        req = 2'b00;

        // External START in IDLE on the same edge as a request.
        wait_free("pre_arb");
        req    = 2'b01;
        sda_in = 1'b0;
        tick();
        check("arb_lost", 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("arb_fsm", int'(dut.state), int'(BUSY_EXT));
        tick();
        check("arb_hold", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        scl_in = 1'b0; tick();
        sda_in = 1'b1; tick();
        scl_in = 1'b1; tick();
        check("ext_quiet", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        sda_in = 1'b0; tick();
        check("ext_rstart", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        scl_in = 1'b0; tick();
        scl_in = 1'b1; tick();
        sda_in = 1'b1; tick();
        check("ext_stop", 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_free("post_stop");
        grant_tick("post_stop_grant", 2'b01);
        do_release("post_stop_rel", 2'b01);
        req = 2'b00;

        // SCL glitch low at count 10 restarts the free window.
        for (int i = 0; i < 10; i++) tick();
        check_val("cnt_at_10", int'(dut.free_cnt), 10);
        scl_in = 1'b0;
        tick();
        check_val("cnt_cleared", int'(dut.free_cnt), 0);
        check("cnt_cleared_out", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        scl_in = 1'b1;
        wait_free("refresh");

        // Asynchronous reset in the middle of a grant.
        req = 2'b01;
        grant_tick("pre_rst_grant", 2'b01);
        #2 reset = 1'b1;
        #1 check("async_rst", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge fast_clock);
        reset = 1'b0;
        #1 check_val("post_rst_fsm", int'(dut.state), int'(WAIT_FREE));
        req = 2'b11;
        @(negedge fast_clock);
        // One cycle already elapsed above; finish the window by hand.
        check("post_rst_c1", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 15; i++) begin
            tick();
            check("post_rst_busy", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        check("post_rst_free", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        grant_tick("post_rst_tie", 2'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
